// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the core's IF/MEM request ports, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the core + memory side.
interface unified_mem_arbiter_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic [DWIDTH-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic [DWIDTH-1:0] d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_we;
    logic [AWIDTH-1:0] m_addr;
    logic [DWIDTH-1:0] m_wdata;
    logic [DWIDTH-1:0] m_rdata;
    logic              m_ready;

    logic              busy;
    logic              grant_d;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, busy, grant_d
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, busy, grant_d
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; a streak counter forces a fetch grant after MAX_STREAK contested data wins.
module unified_mem_arbiter #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [AWIDTH-1:0] m_addr_q, m_addr_d;
    logic [DWIDTH-1:0] m_wdata_q, m_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid, d_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // A port in its ack cycle is still showing the request that just completed.
        if_valid   = bus.if_req & ~if_ack_q;
        d_valid    = bus.d_req & ~d_ack_q;

        case (state_q)
            IDLE: begin
                if (d_valid && (!if_valid || streak_q < STREAK_MAX)) begin
                    state_d   = BUSY_D;
                    streak_d  = if_valid ? streak_q + 4'd1 : '0;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else if (if_valid) begin
                    state_d   = BUSY_IF;
                    streak_d  = '0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                end
            end
            BUSY_IF: begin
                if (bus.m_ready) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    m_we_d     = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus.m_rdata;
                end
            end
            BUSY_D: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    d_ack_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.grant_d  = (state_q == BUSY_D);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random and directed stimulus for unified_mem_arbiter, checked each cycle against
// a transaction-level model of who owns the memory and what each port should see.
module tb_unified_mem_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned MAXS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    unified_mem_arbiter #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .MAX_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: who holds the memory (0 none, 1 fetch, 2 data), the latched
    // transaction, and the values each port must observe.
    int unsigned       own;
    int unsigned       streak;
    logic              exp_if_ack, exp_d_ack, exp_we;
    logic [DW-1:0]     exp_if_rdata, exp_d_rdata, exp_wdata;
    logic [AW-1:0]     exp_addr;

    // Environment: memory contents and responder settings.
    logic [DW-1:0]     mem [logic [AW-1:0]];
    int unsigned       mem_lat, mem_cnt;
    bit                mem_auto, rand_lat, spurious;

    // Requester bookkeeping.
    bit                if_out, d_out, gen_new;
    int unsigned       if_wait, d_wait;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        own = 0; streak = 0;
        exp_if_ack = 1'b0; exp_d_ack = 1'b0; exp_we = 1'b0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_wdata = '0; exp_addr = '0;
    endtask

    task automatic predict();
        bit f_ok, d_ok;
        f_ok = bus.if_req && !exp_if_ack;
        d_ok = bus.d_req && !exp_d_ack;
        exp_if_ack = 1'b0;
        exp_d_ack  = 1'b0;
        if (own == 0) begin
            if (d_ok && (!f_ok || streak < MAXS)) begin
                own = 2;
                streak = f_ok ? streak + 1 : 0;
                exp_addr = bus.d_addr; exp_we = bus.d_we; exp_wdata = bus.d_wdata;
            end else if (f_ok) begin
                own = 1; streak = 0;
                exp_addr = bus.if_addr; exp_we = 1'b0;
            end
        end else if (bus.m_ready) begin
            if (own == 1) begin
                exp_if_ack = 1'b1; exp_if_rdata = bus.m_rdata;
            end else begin
                exp_d_ack = 1'b1;
                if (!exp_we) exp_d_rdata = bus.m_rdata;
            end
            own = 0; exp_we = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("busy", bus.busy, own != 0);
        check_eq("grant_d", bus.grant_d, own == 2);
        check_eq("m_req", bus.m_req, own != 0);
        check_eq("m_we", bus.m_we, exp_we);
        if (own != 0) check_eq("m_addr", bus.m_addr, exp_addr);
        if (own == 2 && exp_we) check_eq("m_wdata", bus.m_wdata, exp_wdata);
        check_eq("if_ack", bus.if_ack, exp_if_ack);
        check_eq("d_ack", bus.d_ack, exp_d_ack);
        check_eq("if_rdata", bus.if_rdata, exp_if_rdata);
        check_eq("d_rdata", bus.d_rdata, exp_d_rdata);
        check_eq("ack_excl", bus.if_ack & bus.d_ack, 0);
    endtask

    task automatic mem_respond();
        if (!mem_auto) return;
        if (bus.m_ready) begin
            bus.m_ready = 1'b0;
            mem_cnt = 0;
        end else if (bus.m_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                bus.m_ready = 1'b1;
                if (bus.m_we) begin
                    mem[bus.m_addr] = bus.m_wdata;
                    bus.m_rdata = $urandom;
                end else begin
                    bus.m_rdata = mem_read(bus.m_addr);
                end
                mem_cnt = 0;
                if (rand_lat) mem_lat = $urandom_range(1, 3);
            end
        end else if (spurious && $urandom_range(0, 15) == 0) begin
            bus.m_ready = 1'b1;
            bus.m_rdata = $urandom;
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        check_all();
        mem_respond();
    endtask

    task automatic drive_reqs();
        if (bus.if_ack) begin
            if_out = 0; if_wait = 0;
        end else if (if_out) begin
            if_wait++;
            if (if_wait > 40) begin
                check_eq("if_ack_timeout", if_wait, 40);
                if_wait = 0;
            end
        end else if (gen_new && $urandom_range(0, 2) != 0) begin
            if_out = 1; bus.if_req = 1'b1;
            bus.if_addr = AW'($urandom_range(0, 15) * 4);
        end else begin
            bus.if_req = 1'b0;
        end

        if (bus.d_ack) begin
            d_out = 0; d_wait = 0;
        end else if (d_out) begin
            d_wait++;
            if (d_wait > 40) begin
                check_eq("d_ack_timeout", d_wait, 40);
                d_wait = 0;
            end
        end else if (gen_new && $urandom_range(0, 2) != 0) begin
            d_out = 1; bus.d_req = 1'b1;
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = AW'($urandom_range(0, 15) * 4);
            bus.d_wdata = $urandom;
        end else begin
            bus.d_req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ready = 1'b0;
        mem_auto = 0; rand_lat = 0; spurious = 0; mem_lat = 1; mem_cnt = 0;
        if_out = 0; d_out = 0; gen_new = 0; if_wait = 0; d_wait = 0;
        model_reset();

        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single fetch with 1-cycle memory.
        mem_auto = 1;
        mem[32'h40] = 32'h8C01_0004;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        tick();
        check_eq("fetch_m_addr", bus.m_addr, 32'h40);
        check_eq("fetch_m_we", bus.m_we, 0);
        check_eq("fetch_early_ack", bus.if_ack, 0);
        tick();
        check_eq("fetch_ack", bus.if_ack, 1);
        check_eq("fetch_rdata", bus.if_rdata, 32'h8C01_0004);
        bus.if_req = 1'b0;
        tick();

        // Store then load of the same word.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("store_m_we", bus.m_we, 1);
        check_eq("store_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        tick();
        check_eq("store_ack", bus.d_ack, 1);
        check_eq("store_rdata_kept", bus.d_rdata, 0);
        bus.d_req = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        tick();
        check_eq("load_m_we", bus.m_we, 0);
        tick();
        check_eq("load_ack", bus.d_ack, 1);
        check_eq("load_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        tick();

        // Request held through its ack cycle is not regranted there.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
        tick();
        check_eq("mask_grant", bus.grant_d, 1);
        tick();
        check_eq("mask_ack", bus.d_ack, 1);
        check_eq("mask_ack_idle", bus.busy, 0);
        tick();
        check_eq("mask_no_regrant", bus.busy, 0);
        tick();
        check_eq("mask_regrant", bus.grant_d, 1);
        tick();
        check_eq("mask_second_ack", bus.d_ack, 1);
        bus.d_req = 1'b0;
        tick();
        tick();

        // Fetch pending while data acks: fetch granted at the end of the ack cycle.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h108;
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        tick();
        check_eq("xport_d_ack", bus.d_ack, 1);
        check_eq("xport_if_quiet", bus.if_ack, 0);
        bus.d_req = 1'b0;
        tick();
        check_eq("xport_if_grant", bus.busy & ~bus.grant_d, 1);
        check_eq("xport_if_addr", bus.m_addr, 32'h44);
        tick();
        check_eq("xport_if_ack", bus.if_ack, 1);
        check_eq("xport_d_quiet", bus.d_ack, 0);
        bus.if_req = 1'b0;
        tick();

        // Simultaneous requests: data first, then random traffic from here on.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10C;
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        tick();
        check_eq("contend_d_first", bus.grant_d, 1);
        if_out = 1; d_out = 1; gen_new = 1;
        rand_lat = 1; spurious = 1;
        drive_reqs();
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_reqs();
        end

        gen_new = 0;
        for (int i = 0; i < 200 && (if_out || d_out || bus.if_ack || bus.d_ack); i++) begin
            tick();
            drive_reqs();
        end
        spurious = 0;
        tick();
        drive_reqs();
        tick();

        // Reset in the middle of a data access.
        mem_auto = 0; bus.m_ready = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h1234_5678;
        tick();
        check_eq("rst_pre_grant", bus.grant_d, 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_m_req", bus.m_req, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_d_ack", bus.d_ack, 0);
        model_reset();
        check_all();
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.m_ready = 1'b1; bus.m_rdata = 32'h55;
        tick();
        check_eq("rst_no_late_ack", bus.d_ack, 0);
        bus.m_ready = 1'b0;
        tick();
        check_eq("rst_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
